// File: rtl/fp_add_bist_pkg.sv
// Shared FP16 constants, BIST state encoding and the FP16 compare helper
// used by the FP16 adder self-test engine.
package fp_add_bist_pkg;

    localparam int FP16_WIDTH = 16;

    localparam logic [FP16_WIDTH-1:0] FP16_POS_ZERO = 16'h0000;
    localparam logic [FP16_WIDTH-1:0] FP16_NEG_ZERO = 16'h8000;
    localparam logic [FP16_WIDTH-1:0] FP16_POS_INF  = 16'h7C00;
    localparam logic [FP16_WIDTH-1:0] FP16_NEG_INF  = 16'hFC00;

    localparam int ROM_DEPTH = 8;

    typedef enum logic [1:0] {
        BIST_IDLE = 2'd0,
        BIST_RUN  = 2'd1,
        BIST_DONE = 2'd2
    } bist_state_t;

    // One ROM entry: operands and the sum a correct adder must return.
    typedef struct packed {
        logic [FP16_WIDTH-1:0] a;
        logic [FP16_WIDTH-1:0] b;
        logic [FP16_WIDTH-1:0] golden;
    } bist_vec_t;

    // True when x is either signed zero.
    function automatic logic fp16_is_zero(input logic [FP16_WIDTH-1:0] x);
        fp16_is_zero = (x == FP16_POS_ZERO) || (x == FP16_NEG_ZERO);
    endfunction

    // Bit-exact compare; optionally treats +0 and -0 as the same value.
    function automatic logic fp16_match(input logic [FP16_WIDTH-1:0] y,
                                        input logic [FP16_WIDTH-1:0] g,
                                        input logic                  zero_eq);
        fp16_match = (y == g) || (zero_eq && fp16_is_zero(y) && fp16_is_zero(g));
    endfunction

endpackage

// File: rtl/fp_add_bist_rom.sv
// Fixed stimulus ROM for the FP16 adder self-test: index -> {a, b, golden}.
module fp_add_bist_rom
    import fp_add_bist_pkg::*;
(
    input  logic [2:0]                idx,
    output logic [3*FP16_WIDTH-1:0]   word
);

    // Combinational lookup covering ordinary sums, cancellation to zero,
    // infinities and a denormal add.
    always_comb begin
        word = {FP16_POS_ZERO, FP16_POS_ZERO, FP16_POS_ZERO};
        case (idx)
            3'd0: word = {16'h3C00,      16'h4000, 16'h4200};
            3'd1: word = {16'h3E00,      16'h3E00, 16'h4200};
            3'd2: word = {16'h3C00,      16'hBC00, FP16_POS_ZERO};
            3'd3: word = {FP16_POS_ZERO, 16'h4200, 16'h4200};
            3'd4: word = {FP16_POS_INF,  16'h3800, FP16_POS_INF};
            3'd5: word = {FP16_NEG_INF,  16'h3800, FP16_NEG_INF};
            3'd6: word = {16'h0001,      16'h0001, 16'h0002};
            3'd7: word = {16'h4200,      16'h3A00, 16'h4380};
            default: word = {FP16_POS_ZERO, FP16_POS_ZERO, FP16_POS_ZERO};
        endcase
    end

endmodule

// File: rtl/fp_add_bist.sv
// Stimulus/response self-test engine for the external FP16 adder. Drives
// each ROM vector for SETTLE_CYC cycles, compares the adder's sum with the
// golden value and records pass/fail, a failure count and the first failure.
module fp_add_bist
    import fp_add_bist_pkg::*;
#(
    parameter int NUM_VEC    = 8,
    parameter int SETTLE_CYC = 1,
    parameter int ZERO_EQ    = 1
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [FP16_WIDTH-1:0] dut_a,
    output logic [FP16_WIDTH-1:0] dut_b,
    input  logic [FP16_WIDTH-1:0] dut_y,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [3:0]            fail_count,
    output logic [2:0]            first_fail_idx,
    output logic [FP16_WIDTH-1:0] first_fail_y
);

    localparam int               CNT_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [2:0]       LAST_IDX   = 3'(NUM_VEC - 1);
    localparam logic             ZERO_EQ_EN = (ZERO_EQ != 0);

    bist_state_t              state;
    logic [2:0]               idx;
    logic [CNT_W-1:0]         cnt;
    logic [FP16_WIDTH-1:0]    golden;
    logic [2:0]               loadIdx;
    logic [3*FP16_WIDTH-1:0]  romWord;
    bist_vec_t                loadVec;
    logic                     vecMatch;

    // Address of the vector to load next: vector 0 on a new run, else the successor.
    always_comb begin
        loadIdx = 3'd0;
        if (state == BIST_RUN) begin
            loadIdx = idx + 3'd1;
        end
    end

    fp_add_bist_rom uRom (
        .idx  (loadIdx),
        .word (romWord)
    );

    assign loadVec  = romWord;
    assign vecMatch = fp16_match(dut_y, golden, ZERO_EQ_EN);

    // Run control: vector sequencing, settle timing and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= BIST_IDLE;
            idx            <= 3'd0;
            cnt            <= '0;
            golden         <= '0;
            dut_a          <= '0;
            dut_b          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= 4'd0;
            first_fail_idx <= 3'd0;
            first_fail_y   <= '0;
        end else begin
            case (state)
                BIST_IDLE, BIST_DONE: begin
                    if (start) begin
                        state          <= BIST_RUN;
                        idx            <= 3'd0;
                        cnt            <= CNT_RELOAD;
                        dut_a          <= loadVec.a;
                        dut_b          <= loadVec.b;
                        golden         <= loadVec.golden;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        fail_count     <= 4'd0;
                        first_fail_idx <= 3'd0;
                        first_fail_y   <= '0;
                    end
                end
                BIST_RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        if (!vecMatch) begin
                            if (fail_count != 4'd15) begin
                                fail_count <= fail_count + 4'd1;
                            end
                            if (fail_count == 4'd0) begin
                                first_fail_idx <= idx;
                                first_fail_y   <= dut_y;
                            end
                        end
                        if (idx != LAST_IDX) begin
                            idx    <= idx + 3'd1;
                            cnt    <= CNT_RELOAD;
                            dut_a  <= loadVec.a;
                            dut_b  <= loadVec.b;
                            golden <= loadVec.golden;
                        end else begin
                            state <= BIST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (fail_count == 4'd0) && vecMatch;
                        end
                    end
                end
                default: begin
                    state <= BIST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_bist.sv
// Self-checking bench for fp_add_bist. Three engines (default, strict zero
// compare, and SETTLE_CYC=3/NUM_VEC=4) share one stimulus; each sees an
// adder stand-in whose result can be corrupted per vector.
module tb_fp_add_bist;

    localparam int NDUT = 3;
    localparam int NV[NDUT] = '{8, 8, 4};
    localparam int SC[NDUT] = '{1, 1, 3};
    localparam int ZE[NDUT] = '{1, 0, 1};

    localparam logic [15:0] VEC_A[8] = '{16'h3C00, 16'h3E00, 16'h3C00, 16'h0000,
                                         16'h7C00, 16'hFC00, 16'h0001, 16'h4200};
    localparam logic [15:0] VEC_B[8] = '{16'h4000, 16'h3E00, 16'hBC00, 16'h4200,
                                         16'h3800, 16'h3800, 16'h0001, 16'h3A00};
    localparam logic [15:0] VEC_Y[8] = '{16'h4200, 16'h4200, 16'h0000, 16'h4200,
                                         16'h7C00, 16'hFC00, 16'h0002, 16'h4380};

    typedef struct packed {
        logic        pass;
        logic [3:0]  fc;
        logic [2:0]  fi;
        logic [15:0] fy;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;

    logic [15:0] aOut[NDUT];
    logic [15:0] bOut[NDUT];
    logic [15:0] yIn[NDUT];
    logic [15:0] ffY[NDUT];
    logic        busyO[NDUT];
    logic        doneO[NDUT];
    logic        passO[NDUT];
    logic [3:0]  fcO[NDUT];
    logic [2:0]  fiO[NDUT];

    logic [7:0]       corruptMask = 8'd0;
    logic [7:0][15:0] corruptY    = '0;

    int   elapsed[NDUT];
    bit   running[NDUT];
    bit   doneSt[NDUT];
    res_t expRes[NDUT];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic int vecIndexOf(input logic [15:0] a, input logic [15:0] b);
        for (int k = 0; k < 8; k++) begin
            if (a == VEC_A[k] && b == VEC_B[k]) return k;
        end
        return -1;
    endfunction

    // Known-good adder results for the operand pairs the engine can present.
    function automatic logic [15:0] adderSum(input logic [15:0] a, input logic [15:0] b);
        int k;
        k = vecIndexOf(a, b);
        if (k >= 0) return VEC_Y[k];
        if (a == 16'h0000 && b == 16'h0000) return 16'h0000;
        return 16'h7E00;
    endfunction

    function automatic logic [15:0] respond(input logic [15:0] a, input logic [15:0] b,
                                            input logic [7:0] mask,
                                            input logic [7:0][15:0] cy);
        int k;
        k = vecIndexOf(a, b);
        if (k >= 0 && mask[k]) return cy[k];
        return adderSum(a, b);
    endfunction

    // Expected end-of-run results from the list of values the adder returns.
    function automatic res_t expectedResults(input int nv, input int ze,
                                             input logic [7:0] mask,
                                             input logic [7:0][15:0] cy);
        res_t        r;
        int          fails;
        int          first;
        logic [15:0] y;
        logic [15:0] g16;
        logic        ok;
        r     = '0;
        fails = 0;
        first = -1;
        for (int k = 0; k < nv; k++) begin
            g16 = VEC_Y[k];
            y   = mask[k] ? cy[k] : g16;
            ok  = (y == g16) || (ze != 0 && y[14:0] == 15'd0 && g16[14:0] == 15'd0);
            if (!ok) begin
                if (first < 0) begin
                    first = k;
                    r.fy  = y;
                end
                fails++;
            end
        end
        r.fc   = (fails > 15) ? 4'd15 : 4'(fails);
        r.pass = (fails == 0);
        r.fi   = (first < 0) ? 3'd0 : 3'(first);
        return r;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        assign yIn[g] = respond(aOut[g], bOut[g], corruptMask, corruptY);

        fp_add_bist #(
            .NUM_VEC    (NV[g]),
            .SETTLE_CYC (SC[g]),
            .ZERO_EQ    (ZE[g])
        ) uDut (
            .clk            (clk),
            .rst_n          (rst_n),
            .start          (start),
            .dut_a          (aOut[g]),
            .dut_b          (bOut[g]),
            .dut_y          (yIn[g]),
            .busy           (busyO[g]),
            .done           (doneO[g]),
            .pass           (passO[g]),
            .fail_count     (fcO[g]),
            .first_fail_idx (fiO[g]),
            .first_fail_y   (ffY[g])
        );
    end

    // Reference timing: a run lasts NUM_VEC*SETTLE_CYC cycles after an accepted start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NDUT; g++) begin
                elapsed[g] <= 0;
                running[g] <= 1'b0;
                doneSt[g]  <= 1'b0;
                expRes[g]  <= '0;
            end
        end else begin
            for (int g = 0; g < NDUT; g++) begin
                if (running[g]) begin
                    elapsed[g] <= elapsed[g] + 1;
                    if (elapsed[g] + 1 == NV[g] * SC[g]) begin
                        running[g] <= 1'b0;
                        doneSt[g]  <= 1'b1;
                        expRes[g]  <= expectedResults(NV[g], ZE[g], corruptMask, corruptY);
                    end
                end else if (start) begin
                    running[g] <= 1'b1;
                    elapsed[g] <= 0;
                    doneSt[g]  <= 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every engine against the reference.
    always @(negedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            logic [15:0] eA;
            logic [15:0] eB;
            eA = 16'h0000;
            eB = 16'h0000;
            if (running[g]) begin
                eA = VEC_A[elapsed[g] / SC[g]];
                eB = VEC_B[elapsed[g] / SC[g]];
            end else if (doneSt[g]) begin
                eA = VEC_A[NV[g] - 1];
                eB = VEC_B[NV[g] - 1];
            end
            checkOutput($sformatf("dut%0d busy", g), 16'(busyO[g]), 16'(running[g]));
            checkOutput($sformatf("dut%0d done", g), 16'(doneO[g]), 16'(doneSt[g]));
            checkOutput($sformatf("dut%0d dut_a", g), aOut[g], eA);
            checkOutput($sformatf("dut%0d dut_b", g), bOut[g], eB);
            if (running[g]) begin
                checkOutput($sformatf("dut%0d pass(run)", g), 16'(passO[g]), 16'd0);
            end else begin
                checkOutput($sformatf("dut%0d pass", g), 16'(passO[g]), 16'(expRes[g].pass));
                checkOutput($sformatf("dut%0d fail_count", g), 16'(fcO[g]), 16'(expRes[g].fc));
                checkOutput($sformatf("dut%0d first_fail_idx", g), 16'(fiO[g]), 16'(expRes[g].fi));
                checkOutput($sformatf("dut%0d first_fail_y", g), ffY[g], expRes[g].fy);
            end
        end
    end

    // One start pulse with the given adder corruption, then wait out the longest run.
    task automatic applyStimulus(input logic [7:0] mask, input logic [7:0][15:0] cy);
        @(negedge clk);
        corruptMask = mask;
        corruptY    = cy;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    initial begin
        logic [7:0][15:0] cy;
        logic [15:0]      g16;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            checkOutput($sformatf("dut%0d reset busy", g), 16'(busyO[g]), 16'd0);
            checkOutput($sformatf("dut%0d reset dut_a", g), aOut[g], 16'h0000);
        end
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] clean run");
        cy = '0;
        applyStimulus(8'h00, cy);
        checkOutput("t1 done", 16'(doneO[0]), 16'd1);
        checkOutput("t1 pass", 16'(passO[0]), 16'd1);
        checkOutput("t1 fail_count", 16'(fcO[0]), 16'd0);
        checkOutput("t1 dut2 pass", 16'(passO[2]), 16'd1);

        $display("[TB] vector 7 returns 4201");
        cy = '0;
        cy[7] = 16'h4201;
        applyStimulus(8'h80, cy);
        checkOutput("t2 pass", 16'(passO[0]), 16'd0);
        checkOutput("t2 fail_count", 16'(fcO[0]), 16'd1);
        checkOutput("t2 first_fail_idx", 16'(fiO[0]), 16'd7);
        checkOutput("t2 first_fail_y", ffY[0], 16'h4201);
        checkOutput("t2 dut2 pass", 16'(passO[2]), 16'd1);

        $display("[TB] adder stuck at FFFF");
        for (int k = 0; k < 8; k++) cy[k] = 16'hFFFF;
        applyStimulus(8'hFF, cy);
        checkOutput("t3 fail_count", 16'(fcO[0]), 16'd8);
        checkOutput("t3 first_fail_idx", 16'(fiO[0]), 16'd0);
        checkOutput("t3 first_fail_y", ffY[0], 16'hFFFF);
        checkOutput("t3 dut2 fail_count", 16'(fcO[2]), 16'd4);

        $display("[TB] restart clears prior failures");
        cy = '0;
        applyStimulus(8'h00, cy);
        checkOutput("t6 restart pass", 16'(passO[0]), 16'd1);
        checkOutput("t6 restart fail_count", 16'(fcO[2]), 16'd0);

        $display("[TB] vector 2 returns negative zero");
        cy = '0;
        cy[2] = 16'h8000;
        applyStimulus(8'h04, cy);
        checkOutput("t4 zero_eq pass", 16'(passO[0]), 16'd1);
        checkOutput("t4 strict pass", 16'(passO[1]), 16'd0);
        checkOutput("t4 strict fail_count", 16'(fcO[1]), 16'd1);
        checkOutput("t4 strict first_fail_idx", 16'(fiO[1]), 16'd2);

        $display("[TB] start re-pulsed mid-run");
        cy = '0;
        corruptMask = 8'h00;
        corruptY    = cy;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);

        $display("[TB] start held high");
        @(negedge clk);
        start = 1'b1;
        repeat (30) @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);

        $display("[TB] reset mid-run");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            checkOutput($sformatf("t5 dut%0d abort busy", g), 16'(busyO[g]), 16'd0);
            checkOutput($sformatf("t5 dut%0d abort done", g), 16'(doneO[g]), 16'd0);
            checkOutput($sformatf("t5 dut%0d abort dut_a", g), aOut[g], 16'h0000);
            checkOutput($sformatf("t5 dut%0d abort dut_b", g), bOut[g], 16'h0000);
            checkOutput($sformatf("t5 dut%0d abort fail_count", g), 16'(fcO[g]), 16'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] randomized adder corruption");
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 8; k++) begin
                g16 = VEC_Y[k];
                case ($urandom_range(0, 2))
                    0:       cy[k] = g16 ^ (16'h0001 << $urandom_range(0, 15));
                    1:       cy[k] = g16 ^ 16'h8000;
                    default: cy[k] = 16'($urandom);
                endcase
            end
            applyStimulus(8'($urandom), cy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
